// File: rtl/id_ex_pkg.sv
// Shared definitions for the decode/operand stage: widths, opcode and
// forwarding-select encodings, and the pipeline-fill sequencer states.
package id_ex_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_N     = 8;
    localparam int REG_NUM_W = 3;

    // Opcode field instr[15:14]
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_MOV = 2'b01;
    localparam logic [1:0] OP_SLL = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // Forwarding select from the forwarding unit
    localparam logic [1:0] FWD_SH_D2 = 2'b00;
    localparam logic [1:0] FWD_WB_D2 = 2'b01;
    localparam logic [1:0] FWD_SH_D1 = 2'b10;
    localparam logic [1:0] FWD_WB_D1 = 2'b11;

    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_FILL  = 2'b01,
        ST_RUN   = 2'b10
    } fill_state_t;

    // MOV selects the move path in EX; every other opcode selects the shifter
    function automatic logic op_is_mov(input logic [1:0] op);
        return (op == OP_MOV);
    endfunction

endpackage

// File: rtl/id_regfile.sv
// 8 x 8-bit register file: two combinational read ports, one write port.
// Optional macro ID_EX_RF_BYPASS_EN makes a same-cycle write visible on
// the read ports (write-first); without it reads return the stored value.
module id_regfile
    import id_ex_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_NUM_W-1:0] rd_num1,
    input  logic [REG_NUM_W-1:0] rd_num2,
    output logic [DATA_W-1:0]    rd_data1,
    output logic [DATA_W-1:0]    rd_data2,
    input  logic                 wr_en,
    input  logic [REG_NUM_W-1:0] wr_num,
    input  logic [DATA_W-1:0]    wr_data
);

    logic [DATA_W-1:0] mem_reg [REG_N];
    logic [REG_N-1:0]  wr_sel;

    // One-hot write select per register
    generate
        for (genvar gi = 0; gi < REG_N; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_num == REG_NUM_W'(gi));
        end
    endgenerate

    // Storage: cleared on reset, written on the rising edge when selected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_N; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_N; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= wr_data;
                end
            end
        end
    end

`ifdef ID_EX_RF_BYPASS_EN
    // Write-first: a write in flight to the register being read wins
    assign rd_data1 = (wr_en && (wr_num == rd_num1)) ? wr_data : mem_reg[rd_num1];
    assign rd_data2 = (wr_en && (wr_num == rd_num2)) ? wr_data : mem_reg[rd_num2];
`else
    // Read-first: the forwarding unit covers the same-cycle hazard
    assign rd_data1 = mem_reg[rd_num1];
    assign rd_data2 = mem_reg[rd_num2];
`endif

endmodule

// File: rtl/id_ex_stage.sv
// Decode/operand stage: decodes the IF/ID instruction, reads the register
// file, captures into the ID/EX register under valid/ready, applies the
// forwarding select to the EX operands, and runs the pipeline-fill
// sequencer that holds forwarding off until the pipe contains real work.
// Optional macro: ID_EX_RF_BYPASS_EN (register-file write-first bypass).
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int FILL_CNT = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 if_id_valid,
    input  logic [15:0]          if_id_instr,
    output logic                 id_ready,
    input  logic                 ex_ready,
    input  logic                 flush,
    input  logic                 wb_we,
    input  logic [REG_NUM_W-1:0] wb_wr_num,
    input  logic [DATA_W-1:0]    wb_wr_data,
    input  logic [1:0]           fwd_ctrl,
    input  logic                 fwd_valid,
    input  logic [DATA_W-1:0]    ex_wb_data1,
    input  logic [DATA_W-1:0]    ex_wb_shift_result,
    output logic                 id_ex_valid,
    output logic [REG_NUM_W-1:0] id_ex_rs1_num,
    output logic [REG_NUM_W-1:0] id_ex_rs2_num,
    output logic [REG_NUM_W-1:0] id_ex_wr_num,
    output logic [1:0]           id_ex_op,
    output logic                 id_ex_smctrl,
    output logic [2:0]           id_ex_shamt,
    output logic [DATA_W-1:0]    ex_data1,
    output logic [DATA_W-1:0]    ex_data2,
    output logic                 fwd_active
);

    // Instruction fields
    logic [1:0]           dec_op;
    logic [REG_NUM_W-1:0] dec_rs1;
    logic [REG_NUM_W-1:0] dec_rs2;
    logic [2:0]           dec_shamt;
    logic                 instr_unused;

    assign dec_op       = if_id_instr[15:14];
    assign dec_rs1      = if_id_instr[13:11];
    assign dec_rs2      = if_id_instr[10:8];
    assign dec_shamt    = if_id_instr[2:0];
    assign instr_unused = ^if_id_instr[7:3];

    logic [DATA_W-1:0] rf_data1;
    logic [DATA_W-1:0] rf_data2;

    id_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_num1  (dec_rs1),
        .rd_num2  (dec_rs2),
        .rd_data1 (rf_data1),
        .rd_data2 (rf_data2),
        .wr_en    (wb_we),
        .wr_num   (wb_wr_num),
        .wr_data  (wb_wr_data)
    );

    // ID/EX pipeline register
    logic                 valid_reg;
    logic [REG_NUM_W-1:0] rs1_num_reg;
    logic [REG_NUM_W-1:0] rs2_num_reg;
    logic [REG_NUM_W-1:0] wr_num_reg;
    logic [1:0]           op_reg;
    logic                 smctrl_reg;
    logic [2:0]           shamt_reg;
    logic [DATA_W-1:0]    data1_reg;
    logic [DATA_W-1:0]    data2_reg;

    logic capture;

    assign id_ready = !valid_reg || ex_ready;
    // A flush swallows the instruction offered in the same cycle
    assign capture  = if_id_valid && id_ready && !flush;

    // ID/EX capture, drain and flush; fields hold whenever nothing is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            rs1_num_reg <= '0;
            rs2_num_reg <= '0;
            wr_num_reg  <= '0;
            op_reg      <= OP_NOP;
            smctrl_reg  <= 1'b0;
            shamt_reg   <= '0;
            data1_reg   <= '0;
            data2_reg   <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (capture) begin
            valid_reg   <= 1'b1;
            rs1_num_reg <= dec_rs1;
            rs2_num_reg <= dec_rs2;
            wr_num_reg  <= dec_rs2;
            op_reg      <= dec_op;
            smctrl_reg  <= op_is_mov(dec_op);
            shamt_reg   <= dec_shamt;
            data1_reg   <= rf_data1;
            data2_reg   <= rf_data2;
        end else if (id_ready) begin
            valid_reg <= 1'b0;
        end
    end

    assign id_ex_valid   = valid_reg;
    assign id_ex_rs1_num = rs1_num_reg;
    assign id_ex_rs2_num = rs2_num_reg;
    assign id_ex_wr_num  = wr_num_reg;
    assign id_ex_op      = op_reg;
    assign id_ex_smctrl  = smctrl_reg;
    assign id_ex_shamt   = shamt_reg;

    // Pipeline-fill sequencer
    fill_state_t state_reg;
    fill_state_t state_next;
    logic [1:0]  fill_cnt_reg;
    logic [1:0]  fill_cnt_next;

    // Sequencer state and fill counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_RESET;
            fill_cnt_reg <= 2'd0;
        end else begin
            state_reg    <= state_next;
            fill_cnt_reg <= fill_cnt_next;
        end
    end

    // Next state: count captures in FILL (saturating), go to RUN at FILL_CNT
    always_comb begin
        state_next    = state_reg;
        fill_cnt_next = fill_cnt_reg;
        case (state_reg)
            ST_RESET: begin
                state_next    = ST_FILL;
                fill_cnt_next = 2'd0;
            end
            ST_FILL: begin
                if (capture && (fill_cnt_reg != 2'b11)) begin
                    fill_cnt_next = fill_cnt_reg + 2'd1;
                end
                if (int'(fill_cnt_next) >= FILL_CNT) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next    = ST_RESET;
                fill_cnt_next = 2'd0;
            end
        endcase
    end

    assign fwd_active = (state_reg == ST_RUN);

    // Forwarding mux: replace one operand when a live match is reported
    always_comb begin
        ex_data1 = data1_reg;
        ex_data2 = data2_reg;
        if (fwd_active && fwd_valid && valid_reg) begin
            case (fwd_ctrl)
                FWD_SH_D2: ex_data2 = ex_wb_shift_result;
                FWD_WB_D2: ex_data2 = ex_wb_data1;
                FWD_SH_D1: ex_data1 = ex_wb_shift_result;
                FWD_WB_D1: ex_data1 = ex_wb_data1;
                default:   ex_data1 = data1_reg;
            endcase
        end
    end

endmodule
